// File: rtl/stream_rr_sched_if.sv
// Stream bundle for stream_rr_sched: N_INP packed input streams plus one
// output stream, the routed index and the lock flag.
// Optional macro STREAM_RR_SCHED_LAST_LOCK_EN adds per-input last and output last.
// master: the scheduler side. slave: the environment (sources and sink).
interface stream_rr_sched_if #(
  parameter int DATA_W = 32,
  parameter int N_INP  = 2
);
  localparam int LOG_N_INP = (N_INP > 1) ? $clog2(N_INP) : 1;

  logic [N_INP*DATA_W-1:0] inp_data_i;
  logic [N_INP-1:0]        inp_valid_i;
  logic [N_INP-1:0]        inp_ready_o;
  logic [DATA_W-1:0]       oup_data_o;
  logic                    oup_valid_o;
  logic                    oup_ready_i;
  logic [LOG_N_INP-1:0]    sel_o;
  logic                    lock_o;
`ifdef STREAM_RR_SCHED_LAST_LOCK_EN
  logic [N_INP-1:0]        inp_last_i;
  logic                    oup_last_o;

  modport master (
    input  inp_data_i, inp_valid_i, inp_last_i, oup_ready_i,
    output inp_ready_o, oup_data_o, oup_valid_o, oup_last_o, sel_o, lock_o
  );
  modport slave (
    output inp_data_i, inp_valid_i, inp_last_i, oup_ready_i,
    input  inp_ready_o, oup_data_o, oup_valid_o, oup_last_o, sel_o, lock_o
  );
`else
  modport master (
    input  inp_data_i, inp_valid_i, oup_ready_i,
    output inp_ready_o, oup_data_o, oup_valid_o, sel_o, lock_o
  );
  modport slave (
    output inp_data_i, inp_valid_i, oup_ready_i,
    input  inp_ready_o, oup_data_o, oup_valid_o, sel_o, lock_o
  );
`endif
endinterface

// File: rtl/stream_rr_sched.sv
// Round-robin scheduler sharing one valid/ready output stream between N_INP
// input streams. A grant is held for up to MAX_BURST accepted beats, and an
// offered-but-unaccepted beat freezes the selection until it is taken.
// Optional macro STREAM_RR_SCHED_LAST_LOCK_EN: packet mode, a grant is held
// until a beat with last=1 is accepted, including across valid bubbles.
module stream_rr_sched #(
  parameter int DATA_W    = 32,
  parameter int N_INP     = 2,
  parameter int MAX_BURST = 4,
  parameter int LOG_N_INP = (N_INP > 1) ? $clog2(N_INP) : 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  stream_rr_sched_if.master     io
);

  localparam int                   CNT_W    = $clog2(MAX_BURST + 1);
  localparam logic [LOG_N_INP-1:0] LAST_IDX = LOG_N_INP'(N_INP - 1);

  logic                 lock_q, lock_d;
  logic [LOG_N_INP-1:0] sel_q, sel_d;
  logic [LOG_N_INP-1:0] ptr_q, ptr_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;

  logic                 held_valid;
  logic                 eff_lock;
  logic [LOG_N_INP-1:0] rr_sel;
  logic [LOG_N_INP-1:0] scan_idx;
  logic                 scan_found;
  logic [LOG_N_INP-1:0] sel;
  logic                 oup_valid;
  logic                 hs;
  logic                 grant_end;

  // Index increment with explicit wrap, so N_INP need not be a power of two.
  function automatic logic [LOG_N_INP-1:0] wrap_inc(input logic [LOG_N_INP-1:0] idx);
    return (idx == LAST_IDX) ? '0 : idx + 1'b1;
  endfunction

  assign held_valid = io.inp_valid_i[sel_q];

`ifdef STREAM_RR_SCHED_LAST_LOCK_EN
  // A packet keeps its grant through bubbles, so the lock does not depend on valid.
  assign eff_lock  = lock_q;
  assign grant_end = io.inp_last_i[sel];
  assign io.oup_last_o = io.inp_last_i[sel];
`else
  assign eff_lock  = lock_q & held_valid;
  assign grant_end = (32'(cnt_q) + 1) == MAX_BURST;
`endif

  // Round-robin search: first valid input starting at ptr_q, ptr_q if none.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    rr_sel     = ptr_q;
    scan_found = 1'b0;
    scan_idx   = ptr_q;
    for (int i = 0; i < N_INP; i++) begin
      if (!scan_found && io.inp_valid_i[scan_idx]) begin
        rr_sel     = scan_idx;
        scan_found = 1'b1;
      end
      // NOTE: blocking assignment is intended; scan_idx must advance within this pass.
      scan_idx = wrap_inc(scan_idx);
    end
  end

  // Active index: held index while locked, otherwise the arbiter's choice.
  always_comb begin
    if (rst_i) begin
      sel = '0;
    end else if (eff_lock) begin
      sel = sel_q;
    end else begin
      sel = rr_sel;
    end
  end

  assign oup_valid      = !rst_i && io.inp_valid_i[sel];
  assign hs             = oup_valid && io.oup_ready_i;
  assign io.oup_valid_o = oup_valid;
  assign io.oup_data_o  = io.inp_data_i[sel*DATA_W +: DATA_W];
  assign io.sel_o       = sel;
  assign io.lock_o      = lock_q;

  // Ready goes back only to the selected input; nothing is ready during reset.
  always_comb begin
    io.inp_ready_o = '0;
    if (!rst_i) begin
      io.inp_ready_o[sel] = io.oup_ready_i;
    end
  end

  // Grant bookkeeping: burst end, burst continue, stall lock, release on valid drop.
  always_comb begin
    lock_d = lock_q;
    sel_d  = sel_q;
    ptr_d  = ptr_q;
    cnt_d  = cnt_q;
    if (hs && grant_end) begin
      lock_d = 1'b0;
      cnt_d  = '0;
      ptr_d  = wrap_inc(sel);
    end else if (hs) begin
      lock_d = 1'b1;
      sel_d  = sel;
      ptr_d  = wrap_inc(sel);
`ifdef STREAM_RR_SCHED_LAST_LOCK_EN
      cnt_d  = '0;
`else
      cnt_d  = cnt_q + 1'b1;
`endif
    end else if (oup_valid && !io.oup_ready_i) begin
      lock_d = 1'b1;
      sel_d  = sel;
`ifndef STREAM_RR_SCHED_LAST_LOCK_EN
    end else if (lock_q && !held_valid) begin
      lock_d = 1'b0;
      cnt_d  = '0;
`endif
    end
  end

  // State registers, cleared asynchronously so a reset drops any pending grant.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      lock_q <= 1'b0;
      sel_q  <= '0;
      ptr_q  <= '0;
      cnt_q  <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      lock_q <= lock_d;
      sel_q  <= sel_d;
      ptr_q  <= ptr_d;
      cnt_q  <= cnt_d;
    end
  end

`ifndef SYNTHESIS
  // Sources must hold valid and data while their beat is offered but not taken.
  for (genvar k = 0; k < N_INP; k++) begin : g_proto
    a_hold: assert property (@(posedge clk_i) disable iff (rst_i)
      (io.inp_valid_i[k] && !io.inp_ready_o[k]) |=>
      (io.inp_valid_i[k] && $stable(io.inp_data_i[k*DATA_W +: DATA_W])));
  end
`endif

endmodule
